// File: rtl/frogger_pkg.sv
// Shared definitions for the river section of the frogger playfield.
// Contents:
//   state_t                   - scheduler states IDLE / LOAD / RUN / DROWNED
//   RIVER_Y_TOP_DEFAULT       - pixel Y of the top edge of lane 0
//   LANE_H_DEFAULT            - height of one river lane in pixels
//   BASE_SPEED_TABLE          - per-lane wait period at Level 0 (lanes 0..3)
//   base_speed()              - table lookup, wraps for designs with more lanes
//   level_speed()             - max(base - level, 1)
package frogger_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    DROWNED = 2'd3
  } state_t;

  localparam logic [10:0] RIVER_Y_TOP_DEFAULT = 11'd80;
  localparam logic [10:0] LANE_H_DEFAULT      = 11'd40;

  // Lane 0 in the low five bits: {lane3, lane2, lane1, lane0} = {4, 10, 6, 8}.
  localparam logic [19:0] BASE_SPEED_TABLE = {5'd4, 5'd10, 5'd6, 5'd8};

  function automatic logic [4:0] base_speed(input int unsigned lane);
    return BASE_SPEED_TABLE[(lane % 4) * 5 +: 5];
  endfunction

  // base > level guarantees base - level >= 1, otherwise clamp to 1.
  function automatic logic [4:0] level_speed(input logic [4:0] base,
                                             input logic [2:0] level);
    return (base > {2'b00, level}) ? (base - {2'b00, level}) : 5'd1;
  endfunction

endpackage

// File: rtl/river_lane_scheduler_if.sv
// Bundle of all game-side signals of the river lane scheduler.
// Ports (signal direction as seen from the scheduler, i.e. the slave modport):
//   Start, Level[2:0], Frog_Y[10:0], Pad_Collision[NUM_LANES-1:0]   inputs
//   Lane_Step, Lane_Dir [NUM_LANES-1:0], Lane_Speed[5*NUM_LANES-1:0],
//   Carry_Step, Carry_Dir, Drown, Running                            outputs
// The master modport is the game controller side driving the inputs.
interface river_lane_scheduler_if #(
  parameter int NUM_LANES = 4
);
  logic                     Start;
  logic [2:0]               Level;
  logic [10:0]              Frog_Y;
  logic [NUM_LANES-1:0]     Pad_Collision;
  logic [NUM_LANES-1:0]     Lane_Step;
  logic [NUM_LANES-1:0]     Lane_Dir;
  logic [5*NUM_LANES-1:0]   Lane_Speed;
  logic                     Carry_Step;
  logic                     Carry_Dir;
  logic                     Drown;
  logic                     Running;

  modport master (
    output Start, Level, Frog_Y, Pad_Collision,
    input  Lane_Step, Lane_Dir, Lane_Speed, Carry_Step, Carry_Dir, Drown, Running
  );

  modport slave (
    input  Start, Level, Frog_Y, Pad_Collision,
    output Lane_Step, Lane_Dir, Lane_Speed, Carry_Step, Carry_Dir, Drown, Running
  );
endinterface

// File: rtl/lane_timer.sv
// Per-lane pad timer. The counter runs 0..speed in RUN, so one lane step
// happens every speed+1 frames.
// Ports:
//   clk, rst     frame clock, synchronous active-high reset
//   clear        zero the counter (LOAD state)
//   en           count this frame (RUN state)
//   step_en      allow the registered step pulse (scheduler stays in RUN)
//   speed[4:0]   wait period in frames
//   step_cond    combinational: this frame's edge is a step edge
//   step         registered one-cycle step pulse
module lane_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       step_en,
  input  logic [4:0] speed,
  output logic       step_cond,
  output logic       step
);

  logic [4:0] cnt_p0;

  assign step_cond = en && (cnt_p0 == speed);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      step   <= 1'b0;
    end else begin
      step <= step_cond && step_en;
      if (clear) begin
        cnt_p0 <= '0;
      end else if (en) begin
        cnt_p0 <= step_cond ? 5'd0 : cnt_p0 + 5'd1;
      end
    end
  end

endmodule

// File: rtl/river_lane_scheduler.sv
// River lane scheduler: paces the pad rows of each river lane, carries the
// frog along with the pad it stands on and detects drowning after a grace
// period of unsupported frames.
// Ports:
//   frame_clk    one rising edge per video frame
//   Reset        synchronous, active-high
//   bus          river_lane_scheduler_if.slave (Start, Level, Frog_Y,
//                Pad_Collision in; Lane_Step, Lane_Dir, Lane_Speed,
//                Carry_Step, Carry_Dir, Drown, Running out)
module river_lane_scheduler
  import frogger_pkg::*;
#(
  parameter int          NUM_LANES    = 4,
  parameter logic [10:0] RIVER_Y_TOP  = RIVER_Y_TOP_DEFAULT,
  parameter logic [10:0] LANE_H       = LANE_H_DEFAULT,
  parameter int          GRACE_FRAMES = 3
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  river_lane_scheduler_if.slave  bus
);

  localparam int GW = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES + 1);
  localparam logic [GW-1:0] GMAX = GW'(GRACE_FRAMES);

  state_t               state, state_nx;
  logic [4:0]           speed [NUM_LANES];
  logic [NUM_LANES-1:0] in_lane;
  logic [NUM_LANES-1:0] lane_dir;
  logic [NUM_LANES-1:0] step_cond;
  logic [NUM_LANES-1:0] step_q;
  logic [NUM_LANES-1:0] carry_hit;
  logic [GW-1:0]        grace, grace_nx;
  logic                 in_river, supported, drown_now, run_stay;
  logic                 in_run, in_load;
  logic                 carry_step_q, carry_dir_q;

  assign in_run  = (state == RUN);
  assign in_load = (state == LOAD);

  // Lane decode by constant range compares; one extra bit keeps the upper
  // bound from wrapping for tall geometries.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [11:0] LO = 12'(RIVER_Y_TOP) + 12'(k) * 12'(LANE_H);
    localparam logic [11:0] HI = LO + 12'(LANE_H);

    assign in_lane[k]  = ({1'b0, bus.Frog_Y} >= LO) && ({1'b0, bus.Frog_Y} < HI);
    assign lane_dir[k] = 1'(k % 2);
    assign bus.Lane_Speed[5*k +: 5] = speed[k];

    lane_timer u_timer (
      .clk       (frame_clk),
      .rst       (Reset),
      .clear     (in_load),
      .en        (in_run),
      .step_en   (run_stay),
      .speed     (speed[k]),
      .step_cond (step_cond[k]),
      .step      (step_q[k])
    );
  end

  // At most one in_lane bit is set, so masking with it discards the pad
  // collisions of every other lane.
  assign in_river  = |in_lane;
  assign supported = |(in_lane & bus.Pad_Collision);
  assign carry_hit = in_lane & bus.Pad_Collision & step_cond;

  always_comb begin
    grace_nx = '0;
    if (in_river && !supported) begin
      grace_nx = (grace == GMAX) ? grace : grace + 1'b1;
    end
  end

  assign drown_now = in_run && (grace_nx == GMAX);

  // Drowning wins over a simultaneous restart request.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.Start) state_nx = LOAD;
      LOAD:    state_nx = RUN;
      RUN: begin
        if (drown_now)      state_nx = DROWNED;
        else if (bus.Start) state_nx = LOAD;
      end
      DROWNED: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Step and carry pulses are only issued when the next cycle is still RUN,
  // so they never appear in LOAD or DROWNED.
  assign run_stay = in_run && (state_nx == RUN);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state        <= IDLE;
      grace        <= '0;
      carry_step_q <= 1'b0;
      carry_dir_q  <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        speed[k] <= base_speed(unsigned'(k));
      end
    end else begin
      state        <= state_nx;
      carry_step_q <= run_stay && (|carry_hit);
      carry_dir_q  <= run_stay && (|(carry_hit & lane_dir));
      if (in_load) begin
        grace <= '0;
        for (int k = 0; k < NUM_LANES; k++) begin
          speed[k] <= level_speed(base_speed(unsigned'(k)), bus.Level);
        end
      end else if (in_run) begin
        grace <= grace_nx;
      end
    end
  end

  assign bus.Lane_Step  = step_q;
  assign bus.Lane_Dir   = lane_dir;
  assign bus.Carry_Step = carry_step_q;
  assign bus.Carry_Dir  = carry_dir_q;
  assign bus.Drown      = (state == DROWNED);
  assign bus.Running    = in_run;

endmodule

// File: tb/tb_river_lane_scheduler.sv
module tb_river_lane_scheduler;

  localparam int NL = 4;
  localparam int G  = 3;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DROWNED = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  river_lane_scheduler_if #(.NUM_LANES(NL)) bus ();

  river_lane_scheduler #(.NUM_LANES(NL)) dut (
    .frame_clk (clk),
    .Reset     (rst),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int base_tab [NL] = '{8, 6, 10, 4};
  int m_speed [NL];
  int m_state;
  int m_j;       // RUN edges since the last LOAD
  int m_grace;   // consecutive unsupported frames
  bit m_valid = 0;
  logic [NL-1:0]   e_step;
  logic [5*NL-1:0] e_speed;
  logic            e_carry, e_cdir, e_drown, e_running;

  int  fl, ng, nxt;
  bit  stay;
  logic [NL-1:0] cond;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_state = M_IDLE;
      for (int k = 0; k < NL; k++) m_speed[k] = base_tab[k];
      m_j = 0; m_grace = 0;
      e_step = '0; e_carry = 0; e_cdir = 0;
    end else if (m_valid) begin
      e_step = '0; e_carry = 0; e_cdir = 0;
      case (m_state)
        M_IDLE: if (bus.Start) m_state = M_LOAD;
        M_LOAD: begin
          for (int k = 0; k < NL; k++)
            m_speed[k] = (base_tab[k] - int'(bus.Level) < 1) ? 1 : base_tab[k] - int'(bus.Level);
          m_j = 0; m_grace = 0;
          m_state = M_RUN;
        end
        M_RUN: begin
          fl = -1;
          if (bus.Frog_Y >= 11'd80 && bus.Frog_Y < 11'd240) fl = (int'(bus.Frog_Y) - 80) / 40;
          if (fl >= 0 && !bus.Pad_Collision[fl]) ng = (m_grace + 1 > G) ? G : m_grace + 1;
          else ng = 0;
          nxt = (ng == G) ? M_DROWNED : (bus.Start ? M_LOAD : M_RUN);
          stay = (nxt == M_RUN);
          for (int k = 0; k < NL; k++) cond[k] = ((m_j % (m_speed[k] + 1)) == m_speed[k]);
          if (stay) e_step = cond;
          if (stay && fl >= 0 && bus.Pad_Collision[fl] && cond[fl]) begin
            e_carry = 1;
            e_cdir  = 1'(fl % 2);
          end
          m_grace = ng;
          m_j++;
          m_state = nxt;
        end
        default: m_state = M_IDLE;
      endcase
    end
    e_drown   = (m_state == M_DROWNED);
    e_running = (m_state == M_RUN);
    for (int k = 0; k < NL; k++) e_speed[5*k +: 5] = 5'(m_speed[k]);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_lane_step",  32'(bus.Lane_Step),  32'(e_step));
      chk("m_lane_speed", 32'(bus.Lane_Speed), 32'(e_speed));
      chk("m_lane_dir",   32'(bus.Lane_Dir),   32'h0000000a);
      chk("m_carry_step", 32'(bus.Carry_Step), 32'(e_carry));
      chk("m_carry_dir",  32'(bus.Carry_Dir),  32'(e_cdir));
      chk("m_drown",      32'(bus.Drown),      32'(e_drown));
      chk("m_running",    32'(bus.Running),    32'(e_running));
    end
  end

  // ---------------- directed + random stimulus ----------------
  localparam logic [19:0] SPEED_L0 = {5'd4, 5'd10, 5'd6, 5'd8};
  localparam logic [19:0] SPEED_L7 = {5'd1, 5'd3, 5'd1, 5'd1};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_run(input logic [2:0] lv);
    bus.Level = lv;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    chk("run_entry", 32'(bus.Running), 32'd1);
  endtask

  task automatic wait_lane(input int k, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.Lane_Step[k] && n < 40);
  endtask

  int n, cnt, drowns;
  logic [10:0] ysel [8] = '{11'd79, 11'd80, 11'd119, 11'd120, 11'd239, 11'd240, 11'd60, 11'd200};

  initial begin
    rst = 1'b1;
    bus.Start = 1'b0; bus.Level = 3'd0; bus.Frog_Y = 11'd0; bus.Pad_Collision = '0;
    tick(); tick();
    chk("rst_speed",   32'(bus.Lane_Speed), 32'(SPEED_L0));
    chk("rst_running", 32'(bus.Running),    32'd0);
    chk("rst_drown",   32'(bus.Drown),      32'd0);
    chk("rst_step",    32'(bus.Lane_Step),  32'd0);
    rst = 1'b0;

    // Level 0: lane 3 steps 5 frames after RUN entry, then every 5.
    start_run(3'd0);
    chk("l0_speed", 32'(bus.Lane_Speed), 32'(SPEED_L0));
    bus.Level = 3'd5;
    wait_lane(3, n);
    chk("l0_lane3_first", 32'(n), 32'd5);
    wait_lane(3, n);
    chk("l0_lane3_period", 32'(n), 32'd5);
    chk("l0_level_ignored", 32'(bus.Lane_Speed), 32'(SPEED_L0));

    // Level 7 restart from RUN.
    start_run(3'd7);
    chk("l7_speed", 32'(bus.Lane_Speed), 32'(SPEED_L7));
    wait_lane(0, n);
    chk("l7_lane0_first", 32'(n), 32'd2);
    wait_lane(0, n);
    chk("l7_lane0_period", 32'(n), 32'd2);

    // Carry along lane 1 (right).
    bus.Frog_Y = 11'd120; bus.Pad_Collision = 4'b0010;
    tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("carry_vs_step", 32'(bus.Carry_Step), 32'(bus.Lane_Step[1]));
      if (bus.Lane_Step[1]) begin
        cnt++;
        chk("carry_dir", 32'(bus.Carry_Dir), 32'd1);
      end
    end
    chk("carry_seen", 32'(cnt >= 4), 32'd1);

    // Drowning in lane 3; Start during DROWNED is ignored.
    bus.Frog_Y = 11'd200; bus.Pad_Collision = 4'b0000;
    tick();
    chk("dr_f1_drown", 32'(bus.Drown), 32'd0);
    tick();
    chk("dr_f2_running", 32'(bus.Running), 32'd1);
    tick();
    chk("dr_f3_drown", 32'(bus.Drown), 32'd1);
    chk("dr_f3_running", 32'(bus.Running), 32'd0);
    chk("dr_f3_carry", 32'(bus.Carry_Step), 32'd0);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("dr_idle_drown", 32'(bus.Drown), 32'd0);
    tick();
    chk("dr_start_ignored", 32'(bus.Running), 32'd0);

    // Support on frame 2 resets the grace count.
    start_run(3'd0);
    bus.Frog_Y = 11'd200; bus.Pad_Collision = 4'b0000;
    tick();
    bus.Pad_Collision = 4'b1000;
    tick();
    bus.Pad_Collision = 4'b0000;
    tick();
    chk("grace_no_drown", 32'(bus.Drown), 32'd0);
    chk("grace_running", 32'(bus.Running), 32'd1);

    // Above the river never drowns; then reset mid-RUN.
    start_run(3'd7);
    bus.Frog_Y = 11'd60;
    drowns = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.Drown) drowns++;
    end
    chk("above_no_drown", 32'(drowns), 32'd0);
    chk("above_running", 32'(bus.Running), 32'd1);
    bus.Start = 1'b1; rst = 1'b1;
    tick();
    chk("mid_rst_speed",   32'(bus.Lane_Speed), 32'(SPEED_L0));
    chk("mid_rst_step",    32'(bus.Lane_Step),  32'd0);
    chk("mid_rst_carry",   32'(bus.Carry_Step), 32'd0);
    chk("mid_rst_cdir",    32'(bus.Carry_Dir),  32'd0);
    chk("mid_rst_drown",   32'(bus.Drown),      32'd0);
    chk("mid_rst_running", 32'(bus.Running),    32'd0);
    bus.Start = 1'b0; rst = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      bus.Start     = ($urandom_range(0, 9) == 0);
      bus.Level     = 3'($urandom_range(0, 7));
      bus.Frog_Y    = ($urandom_range(0, 1) == 0) ? ysel[$urandom_range(0, 7)]
                                                  : 11'($urandom_range(0, 300));
      bus.Pad_Collision = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/river_lane_scheduler.md
RIVER_LANE_SCHEDULER -- requirements
Module: river_lane_scheduler

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of river lanes sequenced.
REQ-002 SHALL have parameter RIVER_Y_TOP, default 11'd80: pixel Y of the top edge of lane 0.
REQ-003 SHALL have parameter LANE_H, default 11'd40: lane height in pixels; lane k spans [RIVER_Y_TOP+k*LANE_H, RIVER_Y_TOP+(k+1)*LANE_H).
REQ-004 SHALL have parameter GRACE_FRAMES, default 3: consecutive unsupported frames in river before drowning.
REQ-005 Port frame_clk, input, 1: the single clock, one edge per frame.
REQ-006 Port Reset, input, 1: synchronous, active-high reset.
REQ-007 Port Start, input, 1: begin or restart a run at the current Level.
REQ-008 Port Level, input, 3: difficulty, 0..7.
REQ-009 Port Frog_Y, input, 11: frog top-edge Y.
REQ-010 Port Pad_Collision, input, NUM_LANES: bit k = frog overlaps a pad in lane k.
REQ-011 Port Lane_Step, output, NUM_LANES: one-cycle pulse; lane k pads advance one 40-px step.
REQ-012 Port Lane_Dir, output, NUM_LANES: bit k 0=left, 1=right; static per lane.
REQ-013 Port Lane_Speed, output, 5 x NUM_LANES: current wait period per lane, in frames.
REQ-014 Port Carry_Step, output, 1: one-cycle pulse; move frog one step with its pad.
REQ-015 Port Carry_Dir, output, 1: direction for Carry_Step, valid when Carry_Step=1.
REQ-016 Port Drown, output, 1: one-cycle pulse on frog loss in river.
REQ-017 Port Running, output, 1: high in RUN state.

Function
REQ-018 FSM states IDLE, LOAD, RUN, DROWNED; IDLE->LOAD on Start; LOAD->RUN unconditionally after 1 cycle; RUN->DROWNED on drown condition; DROWNED->IDLE after 1 cycle; Start in RUN -> LOAD (restart).
REQ-019 LOAD: Lane_Speed[k] = max(BASE_SPEED[k] - Level, 1), BASE_SPEED = {8,6,10,4} for lanes 0..3; all lane counters cleared to 0; grace counter cleared.
REQ-020 Level changes outside LOAD SHALL NOT affect Lane_Speed until the next LOAD.
REQ-021 Lane_Dir[k] = k[0] (even lanes left, odd lanes right), constant, independent of state.
REQ-022 RUN, per lane: if counter == Lane_Speed[k], Lane_Step[k]=1 next cycle and counter<=0; else counter increments; period = Lane_Speed[k]+1 frames.
REQ-023 Lane_Step SHALL be 0 in every state other than RUN; counters hold in IDLE/DROWNED.
REQ-024 Frog lane: frog in lane k iff Frog_Y within lane k's span (REQ-003); Frog_Y < RIVER_Y_TOP or >= RIVER_Y_TOP+NUM_LANES*LANE_H = not in river; decoded by range compare, no divider.
REQ-025 Carry: in RUN, if frog in lane k, Pad_Collision[k]=1 and lane k's step condition is true, Carry_Step=1 and Carry_Dir=Lane_Dir[k], registered on the same edge as Lane_Step[k].
REQ-026 Pad_Collision bits for lanes other than the frog's lane SHALL be ignored.
REQ-027 Grace counter: in RUN, increments when frog in river and Pad_Collision[frog lane]=0; clears when frog out of river or supported; saturates at GRACE_FRAMES.
REQ-028 Drown condition: grace counter reaches GRACE_FRAMES; Drown=1 for exactly the one cycle in DROWNED; no Carry_Step that cycle.
REQ-029 Start while in DROWNED SHALL be ignored; it is honoured from IDLE.

Reset
REQ-030 Reset SHALL, on a frame_clk edge, force state IDLE, all counters 0, Lane_Speed[k]=BASE_SPEED[k], Lane_Step=0, Carry_Step=0, Carry_Dir=0, Drown=0, Running=0.
REQ-031 Reset SHALL override Start and any in-progress run in the same cycle.

Structure
REQ-032 State enum, BASE_SPEED table, lane geometry constants (RIVER_Y_TOP, LANE_H) SHALL live in shared package frogger_pkg.
REQ-033 Per-lane counter/step logic SHALL be sub-module lane_timer, instantiated NUM_LANES times.

Verification
REQ-034 Reset, Start, Level=0 -> Lane_Speed={8,6,10,4}; Lane_Step[3] first pulses 5 cycles after RUN entry, then every 5 cycles.
REQ-035 Start with Level=7 -> Lane_Speed={1,1,3,1}; lane 0 steps every 2 frames.
REQ-036 Frog_Y=120 (lane 1), Pad_Collision=4'b0010 -> each Lane_Step[1] coincides with Carry_Step=1, Carry_Dir=1.
REQ-037 Frog_Y=200, Pad_Collision=0 for 3 frames -> Drown single pulse, Running=0, then IDLE; Pad_Collision=4'b1000 on frame 2 -> no Drown.
REQ-038 Reset asserted mid-RUN -> next edge all outputs at reset values; Frog_Y=60 (above river) never drowns.
